// File: rtl/lsu_mem_issue.sv
// LSU memory issue stage: pops one packed request from the LSU queue head and issues it on the
// data-memory port. It then waits for the acknowledge and returns a tagged completion to
// writeback. Only one transaction is outstanding at a time. A watchdog turns a lost acknowledge
// into an error completion.
module lsu_mem_issue #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned REQ_W   = 1 + TAG_W + DATA_W / 8 + ADDR_W + DATA_W,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  // request queue head
  input  logic [REQ_W-1:0]    q_data_i,
  input  logic                q_valid_i,
  output logic                q_pop_o,
  // data-memory port
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_mask_o,
  output logic                mem_wr_o,
  output logic                mem_req_o,
  input  logic                mem_accept_i,
  input  logic                mem_ack_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  input  logic                mem_error_i,
  // completion to writeback
  output logic                resp_valid_o,
  input  logic                resp_ready_i,
  output logic [TAG_W-1:0]    resp_tag_o,
  output logic [DATA_W-1:0]   resp_data_o,
  output logic                resp_wr_o,
  output logic                resp_error_o,
  output logic                busy_o
);

  localparam int unsigned MaskW   = DATA_W / 8;
  // Field positions inside the packed request {wr, tag, mask, addr, wdata}
  localparam int unsigned AddrLsb = DATA_W;
  localparam int unsigned MaskLsb = AddrLsb + ADDR_W;
  localparam int unsigned TagLsb  = MaskLsb + MaskW;
  localparam int unsigned WrBit   = TagLsb + TAG_W;

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StResp
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         wd_q, wd_d;

  logic                req_wr_q;
  logic [TAG_W-1:0]    req_tag_q;
  logic [MaskW-1:0]    req_mask_q;
  logic [ADDR_W-1:0]   req_addr_q;
  logic [DATA_W-1:0]   req_wdata_q;

  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;

  logic                q_wr;
  logic [MaskW-1:0]    q_mask;

  assign q_wr   = q_data_i[WrBit];
  assign q_mask = q_data_i[MaskLsb +: MaskW];

  // Next state, pop strobe, watchdog and response capture
  always_comb begin
    state_d    = state_q;
    wd_d       = wd_q;
    q_pop_o    = 1'b0;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        // Gated by reset so the strobe is low while the block is held in reset
        if (q_valid_i && !rst_i) begin
          q_pop_o = 1'b1;
          state_d = StReq;
        end
      end
      StReq: begin
        if (mem_accept_i) begin
          wd_d = '0;
          if (mem_ack_i) begin
            rsp_data_d = (req_wr_q || mem_error_i) ? '0 : mem_rdata_i;
            rsp_err_d  = mem_error_i;
            state_d    = StResp;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (mem_ack_i) begin
          rsp_data_d = (req_wr_q || mem_error_i) ? '0 : mem_rdata_i;
          rsp_err_d  = mem_error_i;
          state_d    = StResp;
        end else if (wd_q == TimeoutLast) begin
          // Acknowledge presumed lost: complete with an error
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = StResp;
        end else if (wd_q != 16'hFFFF) begin
          wd_d = wd_q + 16'd1;
        end
      end
      StResp: begin
        if (resp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and watchdog registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

  // Request registers, loaded on pop; loads carry an all-ones byte mask
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_wr_q    <= 1'b0;
      req_tag_q   <= '0;
      req_mask_q  <= '0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
    end else if (q_pop_o) begin
      req_wr_q    <= q_wr;
      req_tag_q   <= q_data_i[TagLsb +: TAG_W];
      req_mask_q  <= q_wr ? q_mask : '1;
      req_addr_q  <= q_data_i[AddrLsb +: ADDR_W];
      req_wdata_q <= q_data_i[DATA_W-1:0];
    end
  end

  // Completion payload registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign mem_req_o    = (state_q == StReq);
  assign mem_addr_o   = req_addr_q;
  assign mem_wdata_o  = req_wdata_q;
  assign mem_mask_o   = req_mask_q;
  assign mem_wr_o     = req_wr_q;

  assign resp_valid_o = (state_q == StResp);
  assign resp_tag_o   = req_tag_q;
  assign resp_data_o  = rsp_data_q;
  assign resp_wr_o    = req_wr_q;
  assign resp_error_o = rsp_err_q;

  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_lsu_mem_issue.sv
// Bench for lsu_mem_issue: table of request vectors driven through a queue model, a memory
// responder and a sink; completions are checked against a scoreboard of expected results.
module tb_lsu_mem_issue;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TW = 4;
  localparam int unsigned MW = DW / 8;
  localparam int unsigned RW = 1 + TW + MW + AW + DW;
  localparam int NV = 13;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [RW-1:0] q_data_i;
  logic          q_valid_i;
  logic          q_pop_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [MW-1:0] mem_mask_o;
  logic          mem_wr_o;
  logic          mem_req_o;
  logic          mem_accept_i;
  logic          mem_ack_i;
  logic [DW-1:0] mem_rdata_i;
  logic          mem_error_i;
  logic          resp_valid_o;
  logic          resp_ready_i;
  logic [TW-1:0] resp_tag_o;
  logic [DW-1:0] resp_data_o;
  logic          resp_wr_o;
  logic          resp_error_o;
  logic          busy_o;

  lsu_mem_issue #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TAG_W  (TW),
    .REQ_W  (RW),
    .TIMEOUT(8)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .q_data_i    (q_data_i),
    .q_valid_i   (q_valid_i),
    .q_pop_o     (q_pop_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_mask_o  (mem_mask_o),
    .mem_wr_o    (mem_wr_o),
    .mem_req_o   (mem_req_o),
    .mem_accept_i(mem_accept_i),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .mem_error_i (mem_error_i),
    .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i),
    .resp_tag_o  (resp_tag_o),
    .resp_data_o (resp_data_o),
    .resp_wr_o   (resp_wr_o),
    .resp_error_o(resp_error_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Request inputs, memory behaviour, sink behaviour, and expected results
  typedef struct {
    logic          wr;
    logic [TW-1:0] tag;
    logic [MW-1:0] mask;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
    int            acc_wait;  // REQ cycles before accept
    int            ack_wait;  // WAIT cycles before ack; -1 never
    bit            same_ack;  // ack together with accept
    bit            stray;     // junk acks in REQ-without-accept and RESP
    int            rdy_wait;  // completion cycles before ready
    bit            chain;     // queue together with the next vector
    logic [MW-1:0] x_mask;
    logic [DW-1:0] x_data;
    logic          x_err;
    int            x_lat;     // pop cycle to first resp_valid cycle
  } vec_t;

  vec_t          vec[0:NV-1];
  int            nchecks = 0;
  int            nerr = 0;

  logic [RW-1:0] q_fifo[$];
  int            q_idx[$];
  int            exp_q[$];
  int            cur = -1;
  int            req_seen, wait_cnt, rsp_seen;
  bit            accepted, acked;
  bit            force_ack = 1'b0;
  int            cyc = 0;
  int            pop_cyc[0:NV-1];
  int            last_hs = -1;
  int            grp_pops, grp_pushes;
  int            pops = 0;
  int            pushes = 0;

  function automatic vec_t mk(input logic wr, input logic [TW-1:0] tag, input logic [MW-1:0] mask,
                              input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                              input logic [DW-1:0] rdata, input logic err, input int acc_wait,
                              input int ack_wait, input bit same_ack, input bit stray,
                              input int rdy_wait, input bit chain, input logic [MW-1:0] x_mask,
                              input logic [DW-1:0] x_data, input logic x_err, input int x_lat);
    vec_t v;
    v.wr = wr; v.tag = tag; v.mask = mask; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.err = err; v.acc_wait = acc_wait; v.ack_wait = ack_wait; v.same_ack = same_ack;
    v.stray = stray; v.rdy_wait = rdy_wait; v.chain = chain; v.x_mask = x_mask;
    v.x_data = x_data; v.x_err = x_err; v.x_lat = x_lat;
    return v;
  endfunction

  function automatic logic [127:0] all_outs();
    return {q_pop_o, mem_req_o, mem_addr_o, mem_wdata_o, mem_mask_o, mem_wr_o, resp_valid_o,
            resp_tag_o, resp_data_o, resp_wr_o, resp_error_o, busy_o};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int i);
    q_fifo.push_back({vec[i].wr, vec[i].tag, vec[i].mask, vec[i].addr, vec[i].wdata});
    q_idx.push_back(i);
    pushes++;
    grp_pushes++;
  endtask

  // One clock: drive inputs at the falling edge, sample and score 1ns later
  task automatic step();
    vec_t v;
    bit   hv;
    bit   good_ack;
    @(negedge clk_i);
    rst_i = 1'b0;
    hv = (cur >= 0);
    if (hv) v = vec[cur];
    q_valid_i = (q_fifo.size() > 0);
    if (q_valid_i) q_data_i = q_fifo[0];
    else q_data_i = '0;
    mem_accept_i = hv && !accepted && (req_seen >= v.acc_wait);
    good_ack = hv && !acked && ((accepted && v.ack_wait >= 0 && wait_cnt >= v.ack_wait) ||
                                (v.same_ack && mem_accept_i));
    mem_ack_i = good_ack || force_ack ||
                (hv && v.stray && ((!accepted && !mem_accept_i) || acked));
    mem_rdata_i = good_ack ? v.rdata : 32'hBAD0_BAD0;
    mem_error_i = good_ack ? v.err : 1'b1;
    resp_ready_i = (exp_q.size() == 0) || (rsp_seen >= vec[exp_q[0]].rdy_wait);
    #1;
    if (mem_req_o) begin
      chk("req_has_txn", hv, 1);
      if (hv) chk("mem_fields", {mem_wr_o, mem_mask_o, mem_addr_o, mem_wdata_o},
                  {v.wr, v.x_mask, v.addr, v.wdata});
      req_seen++;
      if (mem_accept_i) begin
        accepted = 1'b1;
        if (good_ack) acked = 1'b1;
      end
    end else if (hv && accepted && !acked && busy_o && !resp_valid_o) begin
      if (good_ack) acked = 1'b1;
      else wait_cnt++;
    end
    if (q_pop_o) begin
      chk("pop_legal", {q_valid_i, busy_o, exp_q.size() == 0}, 3'b101);
      if (grp_pops > 0) chk("pop_after_handshake", cyc - last_hs, 1);
      if (q_fifo.size() > 0) begin
        void'(q_fifo.pop_front());
        cur = q_idx.pop_front();
        exp_q.push_back(cur);
        pop_cyc[cur] = cyc;
        req_seen = 0; wait_cnt = 0; accepted = 1'b0; acked = 1'b0;
      end
      pops++;
      grp_pops++;
    end
    if (resp_valid_o) begin
      if (exp_q.size() == 0) begin
        chk("resp_spurious", resp_valid_o, 1'b0);
      end else begin
        vec_t e;
        e = vec[exp_q[0]];
        chk("resp_fields", {resp_tag_o, resp_data_o, resp_wr_o, resp_error_o},
            {e.tag, e.x_data, e.wr, e.x_err});
        if (rsp_seen == 0) chk("resp_latency", cyc - pop_cyc[exp_q[0]], e.x_lat);
        rsp_seen++;
        if (resp_ready_i) begin
          void'(exp_q.pop_front());
          rsp_seen = 0;
          last_hs = cyc;
        end
      end
    end
    cyc++;
  endtask

  task automatic run_group(input int budget);
    int n;
    n = 0;
    grp_pops = 0;
    last_hs = -1;
    do begin
      step();
      n++;
    end while ((q_fifo.size() > 0 || exp_q.size() > 0) && n < budget);
    chk("group_done", {q_fifo.size() == 0, exp_q.size() == 0}, 2'b11);
    chk("group_pops", grp_pops, grp_pushes);
    grp_pushes = 0;
  endtask

  initial begin
    int n;
    int rel;
    //              wr tag  mask  addr        wdata          rdata          err acc ack same stray rdy chain xmask xdata       xerr lat
    vec[0]  = mk(0, 4'h3, 4'h0, 32'h100, 32'h0,         32'hDEADBEEF, 0, 0,  0, 0, 0, 0, 0, 4'hF, 32'hDEADBEEF, 0, 3);
    vec[1]  = mk(1, 4'h5, 4'h3, 32'h204, 32'h1234,      32'hAAAA5555, 0, 4,  0, 0, 1, 0, 0, 4'h3, 32'h0,        0, 7);
    vec[2]  = mk(0, 4'h7, 4'hF, 32'h300, 32'h0,         32'hFFFFFFFF, 1, 0,  0, 0, 0, 0, 0, 4'hF, 32'h0,        1, 3);
    vec[3]  = mk(0, 4'h9, 4'h0, 32'h400, 32'h0,         32'h0,        0, 0, -1, 0, 0, 0, 0, 4'hF, 32'h0,        1, 10);
    vec[4]  = mk(1, 4'h2, 4'h0, 32'h10,  32'hCAFEF00D,  32'h11112222, 0, 1,  2, 0, 0, 2, 0, 4'h0, 32'h0,        0, 6);
    vec[5]  = mk(0, 4'hA, 4'h5, 32'h500, 32'h0,         32'h01234567, 0, 0,  0, 1, 0, 0, 0, 4'hF, 32'h01234567, 0, 2);
    vec[6]  = mk(1, 4'hB, 4'hC, 32'h604, 32'h55AA55AA,  32'h0BADBEEF, 1, 0,  1, 0, 0, 0, 0, 4'hC, 32'h0,        1, 4);
    vec[7]  = mk(0, 4'h0, 4'hF, 32'h700, 32'h0,         32'h1000,     0, 0,  0, 0, 1, 3, 1, 4'hF, 32'h1000,     0, 3);
    vec[8]  = mk(0, 4'h1, 4'hF, 32'h704, 32'h0,         32'h1001,     0, 0,  0, 0, 0, 0, 1, 4'hF, 32'h1001,     0, 3);
    vec[9]  = mk(0, 4'h2, 4'hF, 32'h708, 32'h0,         32'h1002,     0, 0,  0, 0, 0, 0, 0, 4'hF, 32'h1002,     0, 3);
    vec[10] = mk(0, 4'hC, 4'h0, 32'h800, 32'h0,         32'h77,       0, 0,  7, 0, 0, 0, 0, 4'hF, 32'h77,       0, 10);
    vec[11] = mk(0, 4'hD, 4'h0, 32'h900, 32'h0,         32'h0,        0, 0, -1, 0, 0, 0, 0, 4'hF, 32'h0,        1, 10);
    vec[12] = mk(0, 4'hE, 4'h0, 32'hA00, 32'h0,         32'h13579BDF, 0, 0,  0, 0, 0, 0, 0, 4'hF, 32'h13579BDF, 0, 3);
    grp_pushes = 0;

    // Reset: every output low even with a valid queue head presented
    rst_i = 1'b1;
    q_valid_i = 1'b1;
    q_data_i = '1;
    mem_accept_i = 1'b0;
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    mem_error_i = 1'b0;
    resp_ready_i = 1'b1;
    #1;
    chk("reset_outputs", all_outs(), '0);
    q_valid_i = 1'b0;

    for (int i = 0; i <= 10; i++) begin
      push(i);
      if (vec[i].chain) continue;
      run_group(60);
      if (i == 3) begin
        // Stray acknowledges arriving while idle must be ignored
        force_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
          step();
          chk("idle_stray_ack", {resp_valid_o, busy_o, q_pop_o}, 3'b000);
        end
        force_ack = 1'b0;
      end
    end

    // Reset while waiting for an acknowledge abandons the transaction
    grp_pushes = 0;
    push(11);
    n = 0;
    do begin
      step();
      n++;
    end while (!(cur == 11 && accepted && busy_o && !mem_req_o && !resp_valid_o) && n < 20);
    chk("reached_wait", {cur == 11, busy_o, mem_req_o}, 3'b110);
    grp_pushes = 0;
    push(12);
    @(negedge clk_i);
    rst_i = 1'b1;
    q_valid_i = 1'b1;
    q_data_i = q_fifo[0];
    mem_accept_i = 1'b0;
    mem_ack_i = 1'b0;
    #1;
    chk("reset_in_wait_outputs", all_outs(), '0);
    exp_q.delete();
    cur = -1;
    rsp_seen = 0;
    rel = cyc;
    run_group(40);
    chk("pop_after_reset", pop_cyc[12], rel);
    chk("total_pops", pops, pushes);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/lsu_mem_issue.md
Name: lsu_mem_issue

Overview:
- Downstream consumer of the LSU request queue.
- Pops one packed memory request at a time from the queue head and issues it on the data-memory request/accept port.
- Waits for the memory acknowledge, then returns a tagged completion (load data or store done, with error flag) to the writeback stage.
- Strictly one outstanding transaction; a watchdog converts a lost acknowledge into an error completion.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width (byte mask is DATA_W/8).
- TAG_W, 4, request tag width.
- REQ_W, 1+TAG_W+DATA_W/8+ADDR_W+DATA_W (default 73), packed request width; must equal the queue DATASIZE.
- TIMEOUT, 255, maximum cycles in WAIT before a forced error completion (1..65535).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- q_data_i  in  REQ_W  queue head, valid whenever q_valid_i=1. Packing from MSB to LSB: {wr, tag, mask, addr, wdata}.
- q_valid_i  in  1  queue non-empty.
- q_pop_o  out  1  one-cycle pop strobe.
- mem_addr_o  out  ADDR_W  request address.
- mem_wdata_o  out  DATA_W  store data.
- mem_mask_o  out  DATA_W/8  byte enables; all ones for loads.
- mem_wr_o  out  1  1=store, 0=load.
- mem_req_o  out  1  request valid.
- mem_accept_i  in  1  memory accepted the request this cycle.
- mem_ack_i  in  1  response valid.
- mem_rdata_i  in  DATA_W  load data, valid with mem_ack_i.
- mem_error_i  in  1  bus error, valid with mem_ack_i.
- resp_valid_o  out  1  completion valid.
- resp_ready_i  in  1  completion consumed.
- resp_tag_o  out  TAG_W  tag of the completed request.
- resp_data_o  out  DATA_W  load data; 0 for stores and errors.
- resp_wr_o  out  1  completion belongs to a store.
- resp_error_o  out  1  bus error or timeout.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_i=1): state=IDLE, watchdog=0.
  - All outputs 0: q_pop_o, mem_req_o, mem_*, resp_*, busy_o.
  - Reset mid-transaction abandons the transaction; no completion is emitted and no further pop occurs. The request already popped is lost, by design.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - If q_valid_i=1: q_pop_o=1 combinationally in this same cycle, and q_data_i fields are registered into the request registers.
  - Next state is REQ.
  - q_pop_o is never asserted outside IDLE and never when q_valid_i=0.
- REQ:
  - mem_req_o=1; address, data, mask and wr are stable from registers.
  - On mem_accept_i=1: go to WAIT and clear the watchdog. If mem_ack_i is also 1 in the same cycle, capture the response and go directly to RESP.
  - No timeout applies in REQ; the block stalls indefinitely on backpressure.
- WAIT:
  - mem_req_o=0; the watchdog increments each cycle.
  - On mem_ack_i: capture resp_data = wr ? 0 : (mem_error_i ? 0 : mem_rdata_i), and resp_error = mem_error_i. Go to RESP.
  - If the watchdog reaches TIMEOUT-1 with no ack: resp_error=1, resp_data=0, go to RESP.
  - A mem_ack_i seen in IDLE, REQ (without accept) or RESP is ignored.
- RESP:
  - resp_valid_o=1 with registered tag, data, wr and error; all fields held stable until resp_ready_i=1.
  - On handshake: go to IDLE; resp_valid_o drops next cycle.
- Latency, with zero-wait memory and ready sink:
  - Pop at cycle 0.
  - mem_req_o at cycle 1.
  - Ack at cycle 2 (accept at 1).
  - resp_valid_o at cycle 3.
  - Back in IDLE at 4, so the next pop is at cycle 4: throughput is 1 request per 4 cycles minimum.
- Mask: loads force mem_mask_o to all ones regardless of the packed mask field. A store with mask=0 is still issued unchanged.
- Watchdog is 16 bits, saturating, and cleared on every entry to WAIT.

Test Plan:
- Load, zero-wait: queue holds {wr=0, tag=3, addr=0x100}; mem accepts at once and acks next cycle with rdata=0xDEADBEEF. Required: single q_pop_o pulse at cycle 0; resp at cycle 3 with tag=3, data=0xDEADBEEF, wr=0, error=0.
- Store with backpressure: {wr=1, tag=5, mask=4'b0011, addr=0x204, wdata=0x1234}, mem_accept_i low for 4 cycles. Required: mem_req_o and all fields held stable for 5 cycles; completion has wr=1, data=0, error=0.
- Bus error: load acked with mem_error_i=1 and rdata=0xFFFFFFFF. Required: resp_error_o=1, resp_data_o=0.
- Timeout: TIMEOUT=8, accept given, ack never given. Required: resp_valid_o with error=1 exactly 8 cycles after entering WAIT. A later stray ack arriving in IDLE has no effect.
- Back-to-back with sink stall: 3 queued loads, resp_ready_i low for 3 cycles on the first completion. Required: no second pop until the first completion handshakes; tags come out in order 0,1,2; exactly 3 pops total.
- Reset in WAIT: assert rst_i for 1 cycle. Required: all outputs 0 immediately (async); no completion emitted; next pop occurs only after reset deasserts with q_valid_i=1.
